// File: rtl/load_sched_pkg.sv
// load_sched_pkg: state encoding and default widths shared by the load and store tile schedulers
package load_sched_pkg;
    localparam int XAW = 32;
    localparam int AW = 12;
    localparam int RW = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_t;
endpackage

// File: rtl/load_tile_sched_if.sv
// load_tile_sched_if: row-load handshake between a tile scheduler and the read-master tile loader
interface load_tile_sched_if #(
    parameter int XAW = load_sched_pkg::XAW,
    parameter int AW = load_sched_pkg::AW
);
    import load_sched_pkg::*;
    logic           load_start;
    logic [XAW-1:0] param_raddr;
    logic [AW-1:0]  param_iolen;
    logic           load_done;
    modport master (output load_start, param_raddr, param_iolen, input load_done);
    modport slave (input load_start, param_raddr, param_iolen, output load_done);
endinterface

// File: rtl/load_tile_sched_tile_loop_cnt.sv
// tile_loop_cnt: two-level row/channel counter with byte-address accumulators
module tile_loop_cnt #(
    parameter int XAW = load_sched_pkg::XAW,
    parameter int RW = load_sched_pkg::RW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_init,
    input  logic           i_step,
    input  logic [XAW-1:0] i_base,
    input  logic [XAW-1:0] i_row_stride,
    input  logic [XAW-1:0] i_chan_stride,
    input  logic [RW-1:0]  i_rows,
    input  logic [RW-1:0]  i_chans,
    output logic [XAW-1:0] o_row_addr,
    output logic           o_last_row,
    output logic           o_last_chan
);
    import load_sched_pkg::*;
    logic [XAW-1:0] r_row_addr, r_chan_addr, r_row_stride, r_chan_stride;
    logic [RW-1:0]  r_row_cnt, r_chan_cnt, r_rows, r_chans;
    logic [XAW-1:0] w_next_chan;
    assign w_next_chan = r_chan_addr + r_chan_stride;
    assign o_row_addr  = r_row_addr;
    assign o_last_row  = r_row_cnt == r_rows - RW'(1);
    assign o_last_chan = r_chan_cnt == r_chans - RW'(1);
    // A step on the final row of the final channel is never issued by the scheduler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_addr    <= '0;
            r_chan_addr   <= '0;
            r_row_stride  <= '0;
            r_chan_stride <= '0;
            r_row_cnt     <= '0;
            r_chan_cnt    <= '0;
            r_rows        <= '0;
            r_chans       <= '0;
        end else if (i_init) begin
            r_row_addr    <= i_base;
            r_chan_addr   <= i_base;
            r_row_stride  <= i_row_stride;
            r_chan_stride <= i_chan_stride;
            r_row_cnt     <= '0;
            r_chan_cnt    <= '0;
            r_rows        <= i_rows;
            r_chans       <= i_chans;
        end else if (i_step && !o_last_row) begin
            r_row_cnt  <= r_row_cnt + RW'(1);
            r_row_addr <= r_row_addr + r_row_stride;
        end else if (i_step) begin
            r_row_cnt   <= '0;
            r_chan_cnt  <= r_chan_cnt + RW'(1);
            r_chan_addr <= w_next_chan;
            r_row_addr  <= w_next_chan;
        end
    end
endmodule

// File: rtl/load_tile_sched.sv
// load_tile_sched: issues one loader request per row of a channels x rows strided tile
module load_tile_sched #(
    parameter int XAW = load_sched_pkg::XAW,
    parameter int AW = load_sched_pkg::AW,
    parameter int RW = load_sched_pkg::RW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cfg_start,
    input  logic [XAW-1:0]     i_cfg_base,
    input  logic [XAW-1:0]     i_cfg_row_stride,
    input  logic [XAW-1:0]     i_cfg_chan_stride,
    input  logic [RW-1:0]      i_cfg_rows,
    input  logic [RW-1:0]      i_cfg_chans,
    input  logic [AW-1:0]      i_cfg_row_len,
    output logic               o_busy,
    output logic               o_tile_done,
    load_tile_sched_if.master  ld
);
    import load_sched_pkg::*;
    sched_state_t   r_state, w_next;
    logic [AW-1:0]  r_row_len;
    logic [XAW-1:0] w_row_addr;
    logic           w_degen, w_init, w_step, w_last_row, w_last_chan, w_last;
    assign w_degen = (i_cfg_rows == '0) || (i_cfg_chans == '0) || (i_cfg_row_len == '0);
    // Degenerate tiles skip the counter load so param_* keep the previous tile's values
    assign w_init = (r_state == IDLE) && i_cfg_start && !w_degen;
    assign w_step = (r_state == WAIT) && ld.load_done;
    assign w_last = w_last_row && w_last_chan;
    tile_loop_cnt #(.XAW(XAW), .RW(RW)) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .i_init        (w_init),
        .i_step        (w_step && !w_last),
        .i_base        (i_cfg_base),
        .i_row_stride  (i_cfg_row_stride),
        .i_chan_stride (i_cfg_chan_stride),
        .i_rows        (i_cfg_rows),
        .i_chans       (i_cfg_chans),
        .o_row_addr    (w_row_addr),
        .o_last_row    (w_last_row),
        .o_last_chan   (w_last_chan)
    );
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)  ? (i_cfg_start ? (w_degen ? DONE : ISSUE) : IDLE) :
                 (r_state == ISSUE) ? WAIT :
                 (r_state == WAIT)  ? (ld.load_done ? (w_last ? DONE : ISSUE) : WAIT) :
                 IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row_len <= '0;
        end else begin
            r_state   <= w_next;
            r_row_len <= w_init ? i_cfg_row_len : r_row_len;
        end
    end
    assign o_busy         = r_state != IDLE;
    assign o_tile_done    = r_state == DONE;
    assign ld.load_start  = r_state == ISSUE;
    assign ld.param_raddr = w_row_addr;
    assign ld.param_iolen = r_row_len;
endmodule

// File: doc/load_tile_sched.md
# load_tile_sched

Sequencer that drives the read-master-to-FIFO tile loader through a two-level strided tile: `cfg_chans` channels, each with `cfg_rows` rows of `cfg_row_len` contiguous 32-bit words. It issues one `load_start` per row with that row's byte address and word length, then waits for the loader's `load_done` before issuing the next row. It sits between the layer configuration registers and the tile loader.

## Interface
- XAW, 32, external byte-address width
- AW, 12, row length width in words; matches the loader's `param_iolen`
- RW, 8, width of the row and channel counts
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_start  in  1  one-cycle pulse; latches all cfg_* inputs
- cfg_base  in  XAW  byte address of row 0 of channel 0
- cfg_row_stride  in  XAW  byte offset between consecutive rows
- cfg_chan_stride  in  XAW  byte offset between the first rows of consecutive channels
- cfg_rows  in  RW  rows per channel
- cfg_chans  in  RW  channel count
- cfg_row_len  in  AW  words per row
- busy  out  1  high whenever state is not IDLE
- tile_done  out  1  one-cycle pulse when the tile is complete
- load_start  out  1  one-cycle pulse to the loader
- param_raddr  out  XAW  row byte address; stable from `load_start` until `load_done`
- param_iolen  out  AW  row word count; stable with `param_raddr`
- load_done  in  1  loader completion pulse

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - On `cfg_start`, latch the configuration and set `chan_addr = row_addr = cfg_base`.
  - Clear `row_cnt` and `chan_cnt`.
  - Go to DONE if any of `cfg_rows`, `cfg_chans`, `cfg_row_len` is 0; otherwise go to ISSUE.
- ISSUE
  - `load_start` = 1 for exactly this one cycle.
  - `param_raddr = row_addr`, `param_iolen = row_len`.
  - Go to WAIT.
- WAIT, on `load_done`:
  - If `row_cnt != rows-1`: `row_cnt++`, `row_addr += row_stride`, go to ISSUE.
  - Else if `chan_cnt != chans-1`: `row_cnt = 0`, `chan_cnt++`, `chan_addr += chan_stride`, `row_addr = chan_addr + chan_stride` (the new channel base), go to ISSUE.
  - Else go to DONE.
- DONE
  - `tile_done` = 1 for one cycle.
  - Go to IDLE.
- Address arithmetic is unsigned modulo 2^XAW and wraps silently.
- Counts are RW-bit unsigned, so at most 2^RW − 1 rows and channels.
- `cfg_start` while `busy` is ignored; the latched configuration is not disturbed.
- `load_done` outside WAIT is ignored, including `load_done` in the same cycle as ISSUE.
- `cfg_start` in the DONE cycle is ignored; the caller waits for `busy` = 0.

## Timing
- Reset values: state IDLE, `busy` 0, `tile_done` 0, `load_start` 0, `param_raddr` 0, `param_iolen` 0, all internal counters and addresses 0.
- `rst` asserted mid-tile aborts immediately. No `tile_done` is emitted. The loader is reset by the same `rst`.
- `cfg_start` at cycle 0 → ISSUE at cycle 1, with `load_start`, `busy` and valid `param_*` all in cycle 1.
- `load_done` at cycle k → next `load_start` at cycle k+1.
  - For the last row, `tile_done` is at k+1 and `busy` falls at k+2.
- Degenerate tile: `cfg_start` at 0 → `tile_done` at 1, `busy` 0 at 2, and no `load_start` at all.
- All outputs are registered; there is no combinational path from `load_done` or `cfg_start` to any output.
- `param_*` hold their last value after the tile completes.

## Structure
- Shared package `load_sched_pkg`: state enum (IDLE/ISSUE/WAIT/DONE), default widths XAW/AW/RW.
- The package is also used by the future store-side scheduler.
- One sub-module is natural: `tile_loop_cnt`, a two-level row/channel counter with address accumulators.
  - Inputs: `init`, `step`.
  - Outputs: `row_addr`, `last_row`, `last_chan`.
- The FSM stays in `load_tile_sched`.

## Test plan
- Basic tile: base 0x1000, row_stride 0x100, chan_stride 0x1000, rows 3, chans 2, row_len 16, loader model returning `load_done` 5 cycles after each `load_start`.
  - Required: six `load_start` pulses with raddr 0x1000, 0x1100, 0x1200, 0x2000, 0x2100, 0x2200, all with iolen 16.
  - Required: one `tile_done`.
- Back-to-back: loader returns `load_done` 1 cycle after `load_start` (in WAIT) → consecutive `load_start` pulses 2 cycles apart.
- Degenerate: rows 0 (repeat with row_len 0) → `tile_done` at cycle 1, zero `load_start`, `busy` low at cycle 2.
- Protocol abuse: spurious `load_done` in IDLE, and `cfg_start` with new base 0x8000 mid-tile → ignored; addresses continue from the original base.
- Wrap: base 0xFFFF_FF00, row_stride 0x100, rows 2, chans 1 → raddr 0xFFFF_FF00 then 0x0000_0000.
- Reset mid-WAIT after the 2nd row → all outputs 0 next cycle; a fresh `cfg_start` runs a full correct tile.
